// File: rtl/serial_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add : bit-serial adder/subtractor, one result bit per clock, LSB  |
// | first. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
module serial_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
   logic [WIDTH-1:0] res_shift;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d, c_q, c_d, busy_q, busy_d, done_q, done_d;
   logic             sum_bit, cy_next;

   assign sum_bit = a_q[0] ^ b_q[0] ^ cy_q;
   assign cy_next = (a_q[0] & b_q[0]) | (cy_q & (a_q[0] ^ b_q[0]));

   // The new bit enters at the MSB so the full result is aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign res_shift = sum_bit;
      end else begin : g_wn
         assign res_shift = {sum_bit, res_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      s_d     = s_q;
      c_d     = c_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               cy_d    = sub;
               cnt_d   = '0;
               res_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cy_d  = cy_next;
            res_d = res_shift;
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d   = '0;
               s_d     = res_shift;
               c_d     = cy_next;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d  = cnt_q + CW'(1);
               busy_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         s_q     <= '0;
         c_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         s_q     <= s_d;
         c_q     <= c_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign s    = s_q;
   assign c    = c_q;

endmodule
`default_nettype wire
